ddr2_rd_dqs_capture: RTL and testbench
======================================

// Module: ddr2_rd_dqs_capture
// PURPOSE
//  Read-direction counterpart of the DQS output path: qualifies strobe returned by the DDR2 device
//  during reads, detects read preamble, captures one burst of DQ beats and buffers them for the user side.
//  Sits between the IDDR-sampled DQ/DQS inputs (already in clk domain) and the controller read-data port.
//  Tracks outstanding read commands, flags missing-strobe timeouts and buffer overflow.
// PARAMETERS
//  DQ_WIDTH     8   data bits per beat edge (rise and fall each DQ_WIDTH)
//  BURST_LEN    4   DDR2 burst length in beats (4 or 8); one clk cycle carries 2 beats
//  FIFO_DEPTH   16  read-data buffer depth in 2*DQ_WIDTH words (power of 2)
//  PRE_TIMEOUT  8   max clk cycles in PREAMBLE before timeout
//  MAX_PEND     4   max outstanding read commands
// PORTS
//  clk          in   1            controller clock
//  reset        in   1            async, active-high
//  ctrl_rd_cmd  in   1            one-cycle pulse per READ issued to the device
//  cfg_cas_lat  in   3            CAS latency in clk cycles (2..6), static while busy
//  dqs_rise_in  in   1            DQS level sampled on rising clk edge
//  dqs_fall_in  in   1            DQS level sampled on falling clk edge
//  dq_rise_in   in   DQ_WIDTH     DQ sampled on rising edge
//  dq_fall_in   in   DQ_WIDTH     DQ sampled on falling edge
//  rd_data      out  2*DQ_WIDTH   {fall,rise} word at FIFO head (show-ahead)
//  rd_valid     out  1            FIFO non-empty
//  rd_ready     in   1            user pop; pop when rd_valid && rd_ready
//  busy         out  1            FSM not IDLE or pending != 0
//  timeout_err  out  1            one-cycle pulse: preamble not seen in PRE_TIMEOUT cycles
//  strobe_err   out  1            one-cycle pulse: bad DQS pattern during CAPTURE
//  ovf_err      out  1            one-cycle pulse: beat dropped, FIFO full
// BEHAVIOUR
//  Reset: FSM=IDLE, pending=0, FIFO empty, rd_valid=0, rd_data=0, busy=0, all err pulses 0.
//  States: IDLE, WAIT_CL, PREAMBLE, CAPTURE.
//  - IDLE: ctrl_rd_cmd -> WAIT_CL, cl_cnt loaded with cfg_cas_lat-1.
//  - WAIT_CL: cl_cnt decrements; at 0 -> PREAMBLE, pre_cnt=0.
//  - PREAMBLE: preamble seen = one cycle dqs_rise_in=0&&dqs_fall_in=0; the following cycle with
//    dqs_rise_in=1&&dqs_fall_in=0 is beat pair 0 -> captured that same cycle, enter CAPTURE.
//    pre_cnt increments each cycle; reaching PRE_TIMEOUT -> timeout_err pulse, burst dropped, go to next.
//  - CAPTURE: BURST_LEN/2 beat pairs total (including the one from PREAMBLE), one per cycle;
//    each cycle pushes {dq_fall_in,dq_rise_in}. Pattern != rise=1/fall=0 -> strobe_err, word still pushed.
//  - Next-burst rule (after last beat or timeout): pending>0 -> decrement, PREAMBLE (seamless, pre_cnt=0);
//    else IDLE.
//  Pending: ctrl_rd_cmd while FSM != IDLE increments pending (saturates MAX_PEND, excess ignored);
//    cmd in same cycle as decrement -> pending unchanged.
//  Latency: first beat pair visible on rd_data/rd_valid 1 cycle after its capture cycle.
//  FIFO: push when beat && !full, or full with simultaneous pop; push while full without pop -> drop, ovf_err.
//    Pop on empty ignored. Pointers wrap mod FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
//  Reset mid-burst: everything to reset values immediately; partial burst discarded.
//  cfg_cas_lat outside 2..6: treated as clamped to range.
// STRUCTURE
//  Shared package/include ddr2_rd_pkg: FSM state encodings, BURST_LEN legal values, CAS latency bounds.
//  One sub-module: ddr2_rd_fifo (sync show-ahead FIFO, params WIDTH/DEPTH, push/pop/full/empty/count).
//  Top holds FSM, cl_cnt, pre_cnt, beat counter, pending counter, error pulse registers.
// TESTING
//  1 cmd, CL=3, BL=4, preamble at cycle 4, beats A/B -> rd_data=A then B, 2 words, no errors.
//  Cmd with DQS never toggling, PRE_TIMEOUT=8 -> timeout_err exactly once, FIFO empty, busy drops.
//  3 back-to-back cmds BL=8, rd_ready=1 -> 12 words in order, pending peaks 2, returns 0.
//  rd_ready=0, 5 bursts BL=8 (20 words), depth 16 -> 4 ovf_err pulses, first 16 words retained.
//  Beat pair with dqs_fall_in=1 mid-CAPTURE -> strobe_err one cycle, word still stored.
//  reset asserted during CAPTURE beat 2 -> rd_valid=0, busy=0 next edge; new cmd then works normally.

Source files
------------

// File: rtl/ddr2_rd_pkg.sv
//------------------------------------------------------------------------------
// Module  : ddr2_rd_pkg
// Brief   : Shared encodings and bounds for the DDR2 read-capture path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ddr2_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_CL  = 2'd1,
        ST_PREAMBLE = 2'd2,
        ST_CAPTURE  = 2'd3
    } rd_state_t;

    localparam int         c_BL_SHORT = 4;
    localparam int         c_BL_LONG  = 8;
    localparam logic [2:0] c_CL_MIN   = 3'd2;
    localparam logic [2:0] c_CL_MAX   = 3'd6;

    // Out-of-range CAS latencies behave as the nearest legal value.
    function automatic logic [2:0] clamp_cas_lat(input logic [2:0] cl);
        if (cl < c_CL_MIN)
            return c_CL_MIN;
        else if (cl > c_CL_MAX)
            return c_CL_MAX;
        else
            return cl;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr2_rd_fifo.sv
//------------------------------------------------------------------------------
// Module  : ddr2_rd_fifo
// Brief   : Synchronous show-ahead FIFO; head word reads as zero when empty.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr2_rd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign full    = (r_count == c_FULL);
    assign empty   = (r_count == '0);
    // A full FIFO still accepts a write when the head is leaving in the same cycle.
    assign w_wr_en = push && (!full || pop);
    assign w_rd_en = pop && !empty;
    assign pop_data = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_rd_en)
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/ddr2_rd_dqs_capture.sv
//------------------------------------------------------------------------------
// Module  : ddr2_rd_dqs_capture
// Brief   : Qualifies read DQS, finds the preamble and buffers one burst per READ.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ddr2_rd_dqs_capture
    import ddr2_rd_pkg::*;
#(
    parameter int DQ_WIDTH    = 8,
    parameter int BURST_LEN   = 4,
    parameter int FIFO_DEPTH  = 16,
    parameter int PRE_TIMEOUT = 8,
    parameter int MAX_PEND    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ctrl_rd_cmd,
    input  logic [2:0]            cfg_cas_lat,
    input  logic                  dqs_rise_in,
    input  logic                  dqs_fall_in,
    input  logic [DQ_WIDTH-1:0]   dq_rise_in,
    input  logic [DQ_WIDTH-1:0]   dq_fall_in,
    output logic [2*DQ_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  busy,
    output logic                  timeout_err,
    output logic                  strobe_err,
    output logic                  ovf_err
);

    localparam int c_PAIRS = BURST_LEN / 2;
    localparam int c_BW    = (c_PAIRS > 1) ? $clog2(c_PAIRS) : 1;
    localparam int c_PW    = $clog2(PRE_TIMEOUT + 1);
    localparam int c_QW    = $clog2(MAX_PEND + 1);
    localparam logic [c_BW-1:0] c_BEAT_LAST = c_BW'(c_PAIRS - 1);
    localparam logic [c_PW-1:0] c_PRE_LAST  = c_PW'(PRE_TIMEOUT - 1);
    localparam logic [c_QW-1:0] c_PEND_MAX  = c_QW'(MAX_PEND);

    rd_state_t       r_state;
    rd_state_t       w_state_nxt;
    logic [2:0]      r_cl_cnt;
    logic [c_PW-1:0] r_pre_cnt;
    logic            r_pre_seen;
    logic [c_BW-1:0] r_beat_cnt;
    logic [c_QW-1:0] r_pending;
    logic            r_timeout_err;
    logic            r_strobe_err;
    logic            r_ovf_err;

    logic w_dqs_ok, w_dqs_idle, w_pre_hit, w_pre_expire, w_last_beat;
    logic w_burst_end, w_take_next, w_beat, w_cmd_queue, w_pop;
    logic w_fifo_full, w_fifo_empty;

    assign w_dqs_ok     = dqs_rise_in && !dqs_fall_in;
    assign w_dqs_idle   = !dqs_rise_in && !dqs_fall_in;
    assign w_pre_hit    = (r_state == ST_PREAMBLE) && r_pre_seen && w_dqs_ok;
    assign w_pre_expire = (r_state == ST_PREAMBLE) && !w_pre_hit && (r_pre_cnt == c_PRE_LAST);
    assign w_last_beat  = (r_state == ST_CAPTURE) && (r_beat_cnt == c_BEAT_LAST);
    assign w_burst_end  = w_pre_expire || w_last_beat;
    assign w_take_next  = w_burst_end && (r_pending != '0);
    assign w_beat       = w_pre_hit || (r_state == ST_CAPTURE);
    assign w_cmd_queue  = ctrl_rd_cmd && (r_state != ST_IDLE);
    assign w_pop        = !w_fifo_empty && rd_ready;

    assign rd_valid    = !w_fifo_empty;
    assign busy        = (r_state != ST_IDLE) || (r_pending != '0);
    assign timeout_err = r_timeout_err;
    assign strobe_err  = r_strobe_err;
    assign ovf_err     = r_ovf_err;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (ctrl_rd_cmd) w_state_nxt = ST_WAIT_CL;
            ST_WAIT_CL:  if (r_cl_cnt == 3'd0) w_state_nxt = ST_PREAMBLE;
            ST_PREAMBLE: begin
                if (w_pre_hit)
                    w_state_nxt = ST_CAPTURE;
                else if (w_pre_expire)
                    w_state_nxt = w_take_next ? ST_PREAMBLE : ST_IDLE;
            end
            ST_CAPTURE:  if (w_last_beat) w_state_nxt = w_take_next ? ST_PREAMBLE : ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cl_cnt      <= '0;
            r_pre_cnt     <= '0;
            r_pre_seen    <= 1'b0;
            r_beat_cnt    <= '0;
            r_pending     <= '0;
            r_timeout_err <= 1'b0;
            r_strobe_err  <= 1'b0;
            r_ovf_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (r_state == ST_IDLE)
                r_cl_cnt <= clamp_cas_lat(cfg_cas_lat) - 3'd1;
            else if ((r_state == ST_WAIT_CL) && (r_cl_cnt != 3'd0))
                r_cl_cnt <= r_cl_cnt - 3'd1;

            // Seamless re-entry into PREAMBLE restarts the timeout window and preamble search.
            if ((r_state != ST_PREAMBLE) || w_burst_end)
                r_pre_cnt <= '0;
            else
                r_pre_cnt <= r_pre_cnt + c_PW'(1);
            r_pre_seen <= (r_state == ST_PREAMBLE) && !w_burst_end && !w_pre_hit && w_dqs_idle;

            if (w_pre_hit)
                r_beat_cnt <= c_BW'(1);
            else if (r_state == ST_CAPTURE)
                r_beat_cnt <= r_beat_cnt + c_BW'(1);

            if (w_take_next && !w_cmd_queue)
                r_pending <= r_pending - c_QW'(1);
            else if (w_cmd_queue && !w_take_next && (r_pending != c_PEND_MAX))
                r_pending <= r_pending + c_QW'(1);

            r_timeout_err <= w_pre_expire;
            r_strobe_err  <= (r_state == ST_CAPTURE) && !w_dqs_ok;
            r_ovf_err     <= w_beat && w_fifo_full && !w_pop;
        end
    end

    ddr2_rd_fifo #(
        .WIDTH (2 * DQ_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_beat),
        .push_data ({dq_fall_in, dq_rise_in}),
        .pop       (w_pop),
        .pop_data  (rd_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

endmodule

`default_nettype wire

// File: tb/tb_ddr2_rd_dqs_capture.sv
//------------------------------------------------------------------------------
// Module  : tb_ddr2_rd_dqs_capture
// Brief   : Directed bench for the DDR2 read capture path (BL4 and BL8 instances).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ddr2_rd_dqs_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_rd_cmd = 1'b0;
    logic [2:0]  cfg_cas_lat = 3'd3;
    logic        dqs_rise_in = 1'b0;
    logic        dqs_fall_in = 1'b0;
    logic [7:0]  dq_rise_in = '0;
    logic [7:0]  dq_fall_in = '0;
    logic        rd_ready = 1'b0;

    logic [15:0] rd_data4, rd_data8;
    logic        rd_valid4, rd_valid8, busy4, busy8;
    logic        timeout_err4, timeout_err8, strobe_err4, strobe_err8, ovf_err4, ovf_err8;

    always #5 clk = ~clk;

    ddr2_rd_dqs_capture #(.DQ_WIDTH(8), .BURST_LEN(4), .FIFO_DEPTH(16), .PRE_TIMEOUT(8), .MAX_PEND(4)) dut4 (
        .clk(clk), .reset(reset), .ctrl_rd_cmd(ctrl_rd_cmd), .cfg_cas_lat(cfg_cas_lat),
        .dqs_rise_in(dqs_rise_in), .dqs_fall_in(dqs_fall_in), .dq_rise_in(dq_rise_in), .dq_fall_in(dq_fall_in),
        .rd_data(rd_data4), .rd_valid(rd_valid4), .rd_ready(rd_ready), .busy(busy4),
        .timeout_err(timeout_err4), .strobe_err(strobe_err4), .ovf_err(ovf_err4));

    ddr2_rd_dqs_capture #(.DQ_WIDTH(8), .BURST_LEN(8), .FIFO_DEPTH(16), .PRE_TIMEOUT(8), .MAX_PEND(4)) dut8 (
        .clk(clk), .reset(reset), .ctrl_rd_cmd(ctrl_rd_cmd), .cfg_cas_lat(cfg_cas_lat),
        .dqs_rise_in(dqs_rise_in), .dqs_fall_in(dqs_fall_in), .dq_rise_in(dq_rise_in), .dq_fall_in(dq_fall_in),
        .rd_data(rd_data8), .rd_valid(rd_valid8), .rd_ready(rd_ready), .busy(busy8),
        .timeout_err(timeout_err8), .strobe_err(strobe_err8), .ovf_err(ovf_err8));

    int          errors = 0;
    int          checks = 0;
    logic [15:0] q4[$];
    logic [15:0] q8[$];
    bit          chk4 = 0, chk8 = 0;
    int          pop4, pop8, to4, to8, st4, st8, ov4, ov8;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pops are checked just before the edge that performs them.
    task automatic tick();
        if (chk4 && rd_valid4 && rd_ready) begin
            if (q4.size() == 0) check("q4_extra_word", q4.size(), 1);
            else begin check("rd_data4", rd_data4, q4.pop_front()); pop4++; end
        end
        if (chk8 && rd_valid8 && rd_ready) begin
            if (q8.size() == 0) check("q8_extra_word", q8.size(), 1);
            else begin check("rd_data8", rd_data8, q8.pop_front()); pop8++; end
        end
        @(posedge clk);
        #1;
        if (timeout_err4) to4++;
        if (timeout_err8) to8++;
        if (strobe_err4)  st4++;
        if (strobe_err8)  st8++;
        if (ovf_err4)     ov4++;
        if (ovf_err8)     ov8++;
    endtask

    task automatic clear_stats();
        q4.delete(); q8.delete();
        pop4 = 0; pop8 = 0; to4 = 0; to8 = 0; st4 = 0; st8 = 0; ov4 = 0; ov8 = 0;
    endtask

    task automatic reset_dut();
        chk4 = 0; chk8 = 0; rd_ready = 0; ctrl_rd_cmd = 0;
        dqs_rise_in = 0; dqs_fall_in = 0; dq_rise_in = '0; dq_fall_in = '0;
        reset = 1'b1;
        #2;
        check("rst_valid4", rd_valid4, 0);
        check("rst_valid8", rd_valid8, 0);
        check("rst_busy8", busy8, 0);
        tick();
        reset = 1'b0;
        tick();
        clear_stats();
    endtask

    // n command pulses back to back, then idle until the first PREAMBLE cycle.
    task automatic issue_cmds(input int n, input int cl_eff);
        ctrl_rd_cmd = 1'b1;
        repeat (n) tick();
        ctrl_rd_cmd = 1'b0;
        repeat (cl_eff - (n - 1)) tick();
    endtask

    // One preamble cycle then 'pairs' beat pairs; pair 'bad' carries DQS fall high.
    task automatic send_burst(input int pairs, input logic [7:0] base, input int bad,
                              input bit rec4, input bit rec8);
        dqs_rise_in = 0; dqs_fall_in = 0;
        tick();
        for (int k = 0; k < pairs; k++) begin
            dqs_rise_in = 1'b1;
            dqs_fall_in = (k == bad);
            dq_rise_in  = base + 8'(2 * k);
            dq_fall_in  = base + 8'(2 * k + 1);
            if (rec4) q4.push_back({dq_fall_in, dq_rise_in});
            if (rec8) q8.push_back({dq_fall_in, dq_rise_in});
            tick();
            if (chk8 && k == bad) check("strobe_err8_pulse", strobe_err8, 1);
        end
        dqs_rise_in = 0; dqs_fall_in = 0; dq_rise_in = '0; dq_fall_in = '0;
    endtask

    initial begin
        clear_stats();
        #2;
        check("init_rd_data4", rd_data4, 16'h0000);
        check("init_rd_data8", rd_data8, 16'h0000);
        check("init_busy4", busy4, 0);
        check("init_errs8", {timeout_err8, strobe_err8, ovf_err8}, 3'b000);
        reset_dut();

        // Single BL4 read, CL=3
        cfg_cas_lat = 3'd3; chk4 = 1; rd_ready = 1;
        issue_cmds(1, 3);
        check("t1_empty_before", rd_valid4, 0);
        send_burst(2, 8'hA0, -1, 1, 0);
        repeat (3) tick();
        check("t1_words", pop4, 2);
        check("t1_busy", busy4, 0);
        check("t1_errs", to4 + st4 + ov4, 0);

        // DQS stuck high: timeout after PRE_TIMEOUT cycles in PREAMBLE
        reset_dut();
        cfg_cas_lat = 3'd3;
        dqs_rise_in = 1; dqs_fall_in = 1;
        ctrl_rd_cmd = 1; tick(); ctrl_rd_cmd = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("t2_timeout_pulse", timeout_err4, (i == 11));
        end
        dqs_rise_in = 0; dqs_fall_in = 0;
        check("t2_timeouts8", to8, 1);
        check("t2_busy4", busy4, 0);
        check("t2_busy8", busy8, 0);
        check("t2_empty", rd_valid4, 0);

        // Three back-to-back BL8 reads
        reset_dut();
        cfg_cas_lat = 3'd3; chk8 = 1; rd_ready = 1;
        issue_cmds(3, 3);
        check("t3_pending_peak", dut8.r_pending, 2);
        send_burst(4, 8'h10, -1, 0, 1);
        send_burst(4, 8'h30, -1, 0, 1);
        send_burst(4, 8'h50, -1, 0, 1);
        repeat (4) tick();
        check("t3_words", pop8, 12);
        check("t3_pending_end", dut8.r_pending, 0);
        check("t3_busy", busy8, 0);
        check("t3_errs", to8 + st8 + ov8, 0);

        // Overflow: 6 cmds (one beyond MAX_PEND), 5 bursts of 4 pairs, no pops
        reset_dut();
        cfg_cas_lat = 3'd6; chk8 = 1; rd_ready = 0;
        issue_cmds(6, 6);
        check("t4_pending_sat", dut8.r_pending, 4);
        send_burst(4, 8'h00, -1, 0, 1);
        send_burst(4, 8'h20, -1, 0, 1);
        send_burst(4, 8'h40, -1, 0, 1);
        send_burst(4, 8'h60, -1, 0, 1);
        send_burst(4, 8'h80, -1, 0, 0);
        tick();
        check("t4_ovf_pulses", ov8, 4);
        check("t4_busy", busy8, 0);
        check("t4_valid_full", rd_valid8, 1);
        rd_ready = 1;
        repeat (18) tick();
        check("t4_retained", pop8, 16);
        check("t4_drained", rd_valid8, 0);

        // Bad DQS on pair 2 of a BL8 burst
        reset_dut();
        cfg_cas_lat = 3'd4; chk8 = 1; rd_ready = 1;
        issue_cmds(1, 4);
        send_burst(4, 8'hB0, 2, 0, 1);
        repeat (4) tick();
        check("t5_strobe_count", st8, 1);
        check("t5_words", pop8, 4);
        check("t5_busy", busy8, 0);

        // Reset during CAPTURE beat 2, then a clean read
        reset_dut();
        cfg_cas_lat = 3'd3;
        issue_cmds(1, 3);
        send_burst(2, 8'hD0, -1, 0, 0);
        reset = 1'b1;
        #2;
        check("t6_valid_async", rd_valid8, 0);
        check("t6_busy_async", busy8, 0);
        tick();
        check("t6_busy_edge", busy8, 0);
        check("t6_rd_data", rd_data8, 16'h0000);
        reset = 1'b0;
        tick();
        clear_stats();
        chk8 = 1; rd_ready = 1;
        issue_cmds(1, 3);
        send_burst(4, 8'hC0, -1, 0, 1);
        repeat (4) tick();
        check("t6_words_after", pop8, 4);
        check("t6_errs_after", to8 + st8 + ov8, 0);

        // CAS latency clamping at both ends
        reset_dut();
        cfg_cas_lat = 3'd0; chk4 = 1; rd_ready = 1;
        issue_cmds(1, 2);
        send_burst(2, 8'hE0, -1, 1, 0);
        repeat (3) tick();
        cfg_cas_lat = 3'd7;
        issue_cmds(1, 6);
        send_burst(2, 8'hF0, -1, 1, 0);
        repeat (3) tick();
        check("t7_words", pop4, 4);
        check("t7_errs", to4 + st4 + ov4, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
